// File: rtl/switch_sequence_player.sv
// switch_sequence_player: replays stored 4-bit switch codes as timed hold/gap pulses on S (optional SEQ_PLAYER_LOOP_EN adds a loop input)
module switch_sequence_player #(
  parameter int DEPTH    = 8,
  parameter int HOLD_CYC = 16,
  parameter int GAP_CYC  = 8,
  parameter int CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [3:0]               wr_code,
  input  logic                     clr,
  input  logic                     start,
  input  logic                     abort,
`ifdef SEQ_PLAYER_LOOP_EN
  input  logic                     loop,
`endif
  output logic [3:0]               S,
  output logic                     busy,
  output logic                     done,
  output logic                     wr_err,
  output logic [$clog2(DEPTH):0]   len
);
  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [LW-1:0] len_q, len_d;
  logic [3:0] s_q, s_d;
  logic done_q, done_d, wr_err_q, wr_err_d;
  logic [3:0] mem_q [DEPTH];
  logic wr_ok, last, step, loop_w;
`ifdef SEQ_PLAYER_LOOP_EN
  assign loop_w = loop;
`else
  assign loop_w = 1'b0;
`endif
  assign last = {1'b0, idx_q} == len_q - LW'(1);
  // next state: abort first, then IDLE command decode or HOLD/GAP timing
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    len_d    = len_q;
    s_d      = s_q;
    done_d   = 1'b0;
    wr_err_d = 1'b0;
    wr_ok    = 1'b0;
    step     = 1'b0;
    if (abort) begin
      state_d = IDLE;
      s_d     = 4'd0;
      timer_d = '0;
    end else if (state_q == IDLE) begin
      if (start) begin
        if (len_q != '0) begin
          state_d = HOLD;
          idx_d   = '0;
          s_d     = mem_q[0];
          timer_d = CNT_W'(HOLD_CYC - 1);
        end else done_d = 1'b1;
      end else if (clr) len_d = '0;
      else if (wr_en) begin
        wr_ok    = len_q != LW'(DEPTH);
        len_d    = wr_ok ? len_q + LW'(1) : len_q;
        wr_err_d = !wr_ok;
      end
    end else begin
      wr_err_d = wr_en;
      if (timer_q != '0) timer_d = timer_q - CNT_W'(1);
      else if (state_q == HOLD && GAP_CYC > 0) begin
        state_d = GAP;
        s_d     = 4'd0;
        timer_d = CNT_W'(GAP_CYC - 1);
      end else step = 1'b1;
      if (step) begin
        if (!last || loop_w) begin
          idx_d   = last ? '0 : idx_q + IW'(1);
          state_d = HOLD;
          s_d     = mem_q[idx_d];
          timer_d = CNT_W'(HOLD_CYC - 1);
        end else begin
          state_d = IDLE;
          s_d     = 4'd0;
          done_d  = 1'b1;
        end
      end
    end
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      timer_q  <= '0;
      len_q    <= '0;
      s_q      <= 4'd0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      len_q    <= len_d;
      s_q      <= s_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
    end
  end
  // code storage, contents need no reset
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) mem_q[len_q[IW-1:0]] <= wr_code;
  end
  assign S      = s_q;
  assign busy   = state_q != IDLE;
  assign done   = done_q;
  assign wr_err = wr_err_q;
  assign len    = len_q;
endmodule
